// File: rtl/poly_w1_pack.sv
// poly_w1_pack: packs a 256-coefficient w1 polynomial into its little-endian
// byte encoding. Each coefficient contributes its low W1_BITS bits, and the
// bytes are streamed out one per handshake. range_err flags any coefficient
// outside [0, 2^W1_BITS-1]. The flag never blocks output.
module poly_w1_pack #(
  parameter int W1_BITS = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [8191:0] a1_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic          range_err
);

  localparam int NBYTES = 32 * W1_BITS;
  localparam int BUF_W  = 8 * NBYTES;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q;
  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] packed_d;
  logic [CNT_W-1:0] cnt_q;
  logic             range_err_q;
  logic             range_err_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_last_q;

  // Build the packed bitstream and the range flag from the incoming polynomial.
  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    packed_d    = '0;
    range_err_d = 1'b0;
    for (int i = 0; i < 256; i++) begin
      packed_d[W1_BITS*i +: W1_BITS] = a1_in[32*i +: W1_BITS];
      // Any set bit above the kept field means negative (sign bit) or too large.
      range_err_d = range_err_d | (|a1_in[32*i+W1_BITS +: 32-W1_BITS]);
    end
  end

  // Two-state capture/stream FSM; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // The byte buffer is cleared too, so out_data reads 0 straight after reset.
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      range_err_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            buf_q       <= packed_d;
            range_err_q <= range_err_d;
            cnt_q       <= '0;
            state_q     <= SEND;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        SEND: begin
          if (out_ready) begin
            buf_q <= buf_q >> 8;
            if (out_last_q) begin
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              cnt_q      <= cnt_q + CNT_W'(1);
              out_last_q <= (cnt_q == LAST_IDX - CNT_W'(1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = buf_q[7:0];
  assign out_last  = out_last_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_poly_w1_pack.sv
// Testbench for poly_w1_pack. One instance is built for W1_BITS=6 and one for
// W1_BITS=4. The expected byte stream comes from a bit-level model of the w1
// encoding.
module tb_poly_w1_pack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid_b;
  logic          out_ready_b;
  logic [8191:0] a1_b;
  logic          sel;

  logic       in_valid6, in_ready6, out_valid6, out_last6, range_err6;
  logic       in_valid4, in_ready4, out_valid4, out_last4, range_err4;
  logic [7:0] out_data6, out_data4;

  assign in_valid6 = in_valid_b & ~sel;
  assign in_valid4 = in_valid_b & sel;

  poly_w1_pack #(.W1_BITS(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .a1_in(a1_b),
    .out_valid(out_valid6), .out_ready(out_ready_b), .out_data(out_data6),
    .out_last(out_last6), .range_err(range_err6)
  );

  poly_w1_pack #(.W1_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a1_in(a1_b),
    .out_valid(out_valid4), .out_ready(out_ready_b), .out_data(out_data4),
    .out_last(out_last4), .range_err(range_err4)
  );

  logic       cur_in_ready, cur_out_valid, cur_out_last, cur_range_err;
  logic [7:0] cur_out_data;
  assign cur_in_ready  = sel ? in_ready4  : in_ready6;
  assign cur_out_valid = sel ? out_valid4 : out_valid6;
  assign cur_out_last  = sel ? out_last4  : out_last6;
  assign cur_range_err = sel ? range_err4 : range_err6;
  assign cur_out_data  = sel ? out_data4  : out_data6;

  int         errors = 0;
  int         checks = 0;
  int         coef[256];
  int         wbits;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       exp_rerr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: build the bitstream one bit at a time, then cut it into bytes.
  task automatic model();
    int n = 32 * wbits;
    bit s[];
    logic [7:0] v;
    s = new[256 * wbits];
    for (int i = 0; i < 256; i++)
      for (int b = 0; b < wbits; b++)
        s[wbits*i + b] = bit'((coef[i] >> b) & 1);
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      v = 8'h00;
      for (int j = 0; j < 8; j++) v = v | (8'(s[8*k + j]) << j);
      exp_q.push_back(v);
    end
    exp_rerr = 1'b0;
    for (int i = 0; i < 256; i++)
      if (coef[i] < 0 || coef[i] > (1 << wbits) - 1) exp_rerr = 1'b1;
  endtask

  task automatic drive_coef();
    for (int i = 0; i < 256; i++) a1_b[32*i +: 32] = coef[i];
  endtask

  task automatic rand_poly(input bit oor);
    for (int i = 0; i < 256; i++) coef[i] = int'($urandom_range(0, (1 << wbits) - 1));
    if (oor) coef[$urandom_range(0, 255)] = int'($urandom);
  endtask

  task automatic use_dut(input logic s);
    sel   = s;
    wbits = s ? 4 : 6;
  endtask

  // Present the current coefficients for one edge and check the first-byte latency.
  task automatic accept(input bit keep_valid);
    @(negedge clk);
    check("idle_in_ready", cur_in_ready, 1);
    check("idle_out_valid", cur_out_valid, 0);
    drive_coef();
    in_valid_b = 1'b1;
    @(negedge clk);
    if (!keep_valid) in_valid_b = 1'b0;
    check("first_byte_valid", cur_out_valid, 1);
    check("busy_in_ready", cur_in_ready, 0);
    check("range_err", cur_range_err, exp_rerr);
  endtask

  // Collect bytes against exp_q. The task returns just after the handshake edge
  // of the last byte, or after byte index stop_after-1 when stop_after >= 0.
  task automatic receive(input bit rnd_ready, input bit chk_busy, input int stop_after);
    int n = 32 * wbits;
    int idx = 0;
    int cyc = 0;
    int long_stall = 0;
    bit stalled = 0;
    bit r;
    logic [7:0] saved_d = 8'h00;
    logic saved_l = 1'b0;
    got_q.delete();
    forever begin
      if (cyc++ > 4000) begin
        check("stream_timeout", 1, 0);
        out_ready_b = 1'b0;
        return;
      end
      check("out_valid", cur_out_valid, 1);
      if (stalled) begin
        check("stall_data", cur_out_data, saved_d);
        check("stall_last", cur_out_last, saved_l);
      end
      check($sformatf("byte%0d", idx), cur_out_data, exp_q[idx]);
      check($sformatf("last%0d", idx), cur_out_last, (idx == n - 1));
      if (chk_busy) check("send_in_ready", cur_in_ready, 0);
      if (!rnd_ready) r = 1'b1;
      else if (idx == n - 1 && long_stall < 5) begin
        r = 1'b0;
        long_stall++;
      end else r = 1'($urandom_range(0, 1));
      out_ready_b = r;
      stalled = !r;
      saved_d = cur_out_data;
      saved_l = cur_out_last;
      if (r) begin
        got_q.push_back(cur_out_data);
        idx++;
        if (idx == n || idx == stop_after) begin
          @(posedge clk);
          #1 out_ready_b = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid_b = 1'b0;
    out_ready_b = 1'b0;
    a1_b = '0;
    use_dut(0);
    #2;
    check("rst_in_ready6", in_ready6, 1);
    check("rst_out_valid6", out_valid6, 0);
    check("rst_out_data6", out_data6, 0);
    check("rst_out_last6", out_last6, 0);
    check("rst_range_err6", range_err6, 0);
    check("rst_in_ready4", in_ready4, 1);
    check("rst_out_valid4", out_valid4, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: 6-bit constant 43.
    use_dut(0);
    for (int i = 0; i < 256; i++) coef[i] = 43;
    model();
    accept(0);
    receive(0, 0, -1);
    check("t1_b0", got_q[0], 8'hEB);
    check("t1_b1", got_q[1], 8'hBA);
    check("t1_b2", got_q[2], 8'hAE);
    check("t1_b191", got_q[191], 8'hAE);

    // Test 2: 4-bit ramp.
    use_dut(1);
    for (int i = 0; i < 256; i++) coef[i] = i % 16;
    model();
    accept(0);
    receive(0, 0, -1);
    check("t2_b0", got_q[0], 8'h10);
    check("t2_b7", got_q[7], 8'hFE);
    check("t2_b8", got_q[8], 8'h10);
    check("t2_count", got_q.size(), 128);

    // Test 3: a negative coefficient sets range_err but is still packed.
    use_dut(0);
    for (int i = 0; i < 256; i++) coef[i] = 0;
    coef[5] = -1;
    model();
    accept(0);
    check("t3_rerr", cur_range_err, 1);
    receive(0, 0, -1);
    check("t3_b3", got_q[3], 8'hC0);
    check("t3_b4", got_q[4], 8'h0F);
    check("t3_b5", got_q[5], 8'h00);
    @(negedge clk);
    check("t3_rerr_idle", cur_range_err, 1);
    for (int i = 0; i < 256; i++) coef[i] = 43;
    model();
    accept(0);
    check("t3_rerr_cleared", cur_range_err, 0);
    receive(0, 0, -1);

    // Test 4: random backpressure with a long stall on the last byte.
    model();
    accept(0);
    receive(1, 0, -1);
    check("t4_count", got_q.size(), 192);

    // Test 5: in_valid held with new data during SEND.
    rand_poly(0);
    model();
    accept(1);
    rand_poly(1);
    drive_coef();
    receive(1, 1, -1);
    @(negedge clk);
    check("t5_gap_in_ready", cur_in_ready, 1);
    check("t5_gap_out_valid", cur_out_valid, 0);
    @(negedge clk);
    in_valid_b = 1'b0;
    check("t5_b_accepted", cur_out_valid, 1);
    model();
    check("t5_b_rerr", cur_range_err, exp_rerr);
    receive(0, 0, -1);

    // Test 6: asynchronous reset mid-stream.
    rand_poly(1);
    model();
    accept(0);
    receive(0, 0, 51);
    #2 rst = 1'b1;
    #1;
    check("t6_out_valid", cur_out_valid, 0);
    check("t6_out_data", cur_out_data, 0);
    check("t6_out_last", cur_out_last, 0);
    check("t6_range_err", cur_range_err, 0);
    check("t6_in_ready", cur_in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    rand_poly(0);
    model();
    accept(0);
    receive(0, 0, -1);

    // Random polynomials on both widths.
    for (int r = 0; r < 4; r++) begin
      use_dut(1'(r % 2));
      rand_poly(1'(r / 2));
      model();
      accept(0);
      receive(1, 1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
